// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Purpose: takes branch resolutions from the execute stage. A mispredict
// makes it redirect fetch: one REDIRECT cycle (redirect + flush), then
// RECOVER_CYCLES cycles of RECOVER (stall + flush). Every branch resolved in
// IDLE also goes into a small queue of BTB/predictor updates, which is
// drained through a valid/ready channel.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   ex_valid_i/ex_isBranch_i execute stage holds a valid branch/jump
//   ex_pc_i/ex_next_pc_i     branch PC and resolved next PC
//   ex_need_jump_i           resolved direction (taken)
//   ex_branch_fix_i          direction mispredict
//   ex_addr_fix_i            target mispredict
//   redirect_o/redirect_pc_o fetch redirect pulse and its target
//   flush_o/stall_o          kill fetch/decode contents, hold fetch
//   upd_*                    BTB update channel (queue head, valid/ready)
//
// Optional feature: when the macro BRANCH_STATS_EN is defined, the block
// gains the 32-bit wrapping counters stat_branch_o, stat_mispred_o and
// stat_drop_o.
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int WIDTH          = 32,
    parameter int UPD_DEPTH      = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic             ex_isBranch_i,
    input  logic [WIDTH-1:0] ex_pc_i,
    input  logic [WIDTH-1:0] ex_next_pc_i,
    input  logic             ex_need_jump_i,
    input  logic             ex_branch_fix_i,
    input  logic             ex_addr_fix_i,
    output logic             redirect_o,
    output logic [WIDTH-1:0] redirect_pc_o,
    output logic             flush_o,
    output logic             stall_o,
    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [WIDTH-1:0] upd_pc_o,
    output logic [WIDTH-1:0] upd_target_o,
    output logic             upd_taken_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_branch_o,
    output logic [31:0]      stat_mispred_o,
    output logic [31:0]      stat_drop_o
`endif
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);
    localparam int ENT_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_RECOVER} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_redirect_pc;

    logic [ENT_W-1:0]   r_q_mem [UPD_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;

    logic               w_resolve;
    logic               w_mispredict;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENT_W-1:0]   w_head;

    // Execute-stage inputs only count in IDLE; during REDIRECT/RECOVER
    // they come from the wrong path.
    assign w_resolve    = (r_state == ST_IDLE) & ex_valid_i & ex_isBranch_i;
    assign w_mispredict = w_resolve & (ex_branch_fix_i | ex_addr_fix_i);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_mispredict) w_state_next = ST_REDIRECT;
            ST_REDIRECT: w_state_next = ST_RECOVER;
            ST_RECOVER:  if (r_cnt == CNT_W'(1)) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        redirect_o = 1'b0;
        flush_o    = 1'b0;
        stall_o    = 1'b0;
        case (r_state)
            ST_REDIRECT: begin
                redirect_o = 1'b1;
                flush_o    = 1'b1;
            end
            ST_RECOVER: begin
                stall_o = 1'b1;
                flush_o = 1'b1;
            end
            default: ;
        endcase
    end

    // The recovery counter is loaded during REDIRECT, so RECOVER sees the
    // full count in its first cycle. Leaving when the count is 1 therefore
    // gives exactly RECOVER_CYCLES stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_REDIRECT) begin
            r_cnt <= CNT_W'(RECOVER_CYCLES);
        end else if (r_state == ST_RECOVER) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_pc <= '0;
        end else if (w_mispredict) begin
            r_redirect_pc <= ex_next_pc_i;
        end
    end

    assign redirect_pc_o = r_redirect_pc;

    // ---------------- BTB update queue ----------------
    // A pop in the same cycle frees a slot, so a push into a full queue is
    // accepted then. Otherwise a push into a full queue is dropped, because
    // updates are only hints.
    assign w_full = (r_count == (PTR_W + 1)'(UPD_DEPTH));
    assign w_pop  = (r_count != '0) & upd_ready_i;
    assign w_push = w_resolve & (~w_full | w_pop);
    assign w_drop = w_resolve & w_full & ~w_pop;

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mem[r_wptr] <= {ex_pc_i, ex_next_pc_i, ex_need_jump_i};
        end
    end

    // The pointers span exactly UPD_DEPTH (a power of two), so they wrap
    // on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_q_mem[r_rptr];
    assign upd_valid_o  = (r_count != '0);
    assign upd_pc_o     = w_head[ENT_W-1 -: WIDTH];
    assign upd_target_o = w_head[WIDTH:1];
    assign upd_taken_o  = w_head[0];

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branch;
    logic [31:0] r_stat_mispred;
    logic [31:0] r_stat_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branch  <= '0;
            r_stat_mispred <= '0;
            r_stat_drop    <= '0;
        end else begin
            if (w_resolve)    r_stat_branch  <= r_stat_branch + 32'd1;
            if (w_mispredict) r_stat_mispred <= r_stat_mispred + 32'd1;
            if (w_drop)       r_stat_drop    <= r_stat_drop + 32'd1;
        end
    end

    assign stat_branch_o  = r_stat_branch;
    assign stat_mispred_o = r_stat_mispred;
    assign stat_drop_o    = r_stat_drop;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Bench for branch_resolve_ctrl with RECOVER_CYCLES=2 and UPD_DEPTH=2. It has
// three parts:
//   - a table of directed vectors with hand-derived expected outputs,
//   - hand-written multi-cycle sequences (queue overflow, push+pop when
//     full, reset during RECOVER),
//   - randomized traffic checked against a behavioural model.
// The model keeps a count of the cycles left in the redirect sequence and
// holds the updates in a SystemVerilog queue.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int RC    = 2;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        ex_valid_i, ex_isBranch_i;
    logic [31:0] ex_pc_i, ex_next_pc_i;
    logic        ex_need_jump_i, ex_branch_fix_i, ex_addr_fix_i;
    logic        redirect_o, flush_o, stall_o;
    logic [31:0] redirect_pc_o;
    logic        upd_valid_o, upd_ready_i, upd_taken_o;
    logic [31:0] upd_pc_o, upd_target_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branch_o, stat_mispred_o, stat_drop_o;
`endif

    branch_resolve_ctrl #(
        .WIDTH(32), .UPD_DEPTH(DEPTH), .RECOVER_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_isBranch_i(ex_isBranch_i),
        .ex_pc_i(ex_pc_i), .ex_next_pc_i(ex_next_pc_i),
        .ex_need_jump_i(ex_need_jump_i), .ex_branch_fix_i(ex_branch_fix_i),
        .ex_addr_fix_i(ex_addr_fix_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .stall_o(stall_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
        .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
        .upd_taken_o(upd_taken_o)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branch_o(stat_branch_o), .stat_mispred_o(stat_mispred_o),
        .stat_drop_o(stat_drop_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tkn;
    } upd_t;

    int          m_left;    // cycles left in redirect sequence (1+RC = redirect cycle)
    logic [31:0] m_rpc;
    upd_t        m_q[$];
    int          m_branch, m_mis, m_drop;

    // Advances the model on the current inputs, then clocks the DUT.
    task automatic cycle();
        if (rst) begin
            m_left = 0;
            m_rpc  = 0;
            m_q.delete();
            m_branch = 0; m_mis = 0; m_drop = 0;
        end else begin
            bit res, mis, pop;
            int sz;
            upd_t e;
            sz  = m_q.size();
            res = (m_left == 0) && ex_valid_i && ex_isBranch_i;
            mis = res && (ex_branch_fix_i || ex_addr_fix_i);
            pop = (sz > 0) && upd_ready_i;
            if (m_left > 0) m_left--;
            if (mis) begin
                m_left = 1 + RC;
                m_rpc  = ex_next_pc_i;
            end
            if (pop) void'(m_q.pop_front());
            if (res) begin
                m_branch++;
                if (mis) m_mis++;
                if (sz < DEPTH || pop) begin
                    e.pc = ex_pc_i; e.tgt = ex_next_pc_i; e.tkn = ex_need_jump_i;
                    m_q.push_back(e);
                end else begin
                    m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".redirect"}, 32'(redirect_o), 32'(m_left == 1 + RC));
        chk({tag, ".flush"},    32'(flush_o),    32'(m_left > 0));
        chk({tag, ".stall"},    32'(stall_o),    32'(m_left > 0 && m_left <= RC));
        chk({tag, ".rpc"},      redirect_pc_o,   m_rpc);
        chk({tag, ".uvalid"},   32'(upd_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".upc"},  upd_pc_o,          m_q[0].pc);
            chk({tag, ".utgt"}, upd_target_o,      m_q[0].tgt);
            chk({tag, ".utkn"}, 32'(upd_taken_o),  32'(m_q[0].tkn));
        end
`ifdef BRANCH_STATS_EN
        chk({tag, ".sbr"},  stat_branch_o,  32'(m_branch));
        chk({tag, ".smis"}, stat_mispred_o, 32'(m_mis));
        chk({tag, ".sdrop"}, stat_drop_o,   32'(m_drop));
`endif
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic [31:0] nx, input logic nj, input logic bf,
                         input logic af, input logic rdy);
        rst = 1'b0;
        ex_valid_i = v; ex_isBranch_i = br; ex_pc_i = pc; ex_next_pc_i = nx;
        ex_need_jump_i = nj; ex_branch_fix_i = bf; ex_addr_fix_i = af;
        upd_ready_i = rdy;
    endtask

    task automatic step(input string tag, input logic v, input logic br,
                        input logic [31:0] pc, input logic [31:0] nx,
                        input logic nj, input logic bf, input logic af,
                        input logic rdy);
        drive(v, br, pc, nx, nj, bf, af, rdy);
        cycle();
        check_model(tag);
        $display("%s: pc=%h redir=%b stall=%b uvalid=%b upc=%h", tag, pc,
                 redirect_o, stall_o, upd_valid_o, upd_pc_o);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_model("reset");
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, v, br;
        logic [31:0] pc, nx;
        logic        nj, bf, af, rdy;
        logic        e_redir, e_flush, e_stall;
        logic [31:0] e_rpc;
        logic        e_uv;
        logic [31:0] e_upc, e_utgt;
        logic        e_utk;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic v, input logic br, input logic [31:0] pc,
        input logic [31:0] nx, input logic nj, input logic bf, input logic af,
        input logic rdy, input logic er, input logic ef, input logic es,
        input logic [31:0] erpc, input logic euv, input logic [31:0] eupc,
        input logic [31:0] eutgt, input logic eutk);
        vec_t t;
        t.rst = r; t.v = v; t.br = br; t.pc = pc; t.nx = nx; t.nj = nj;
        t.bf = bf; t.af = af; t.rdy = rdy; t.e_redir = er; t.e_flush = ef;
        t.e_stall = es; t.e_rpc = erpc; t.e_uv = euv; t.e_upc = eupc;
        t.e_utgt = eutgt; t.e_utk = eutk;
        return t;
    endfunction

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam logic [31:0] Z = 32'h0;

    vec_t vecs[12];

    initial begin
        //            rst v  br pc        nx        nj bf af rdy  redir flush stall rpc       uv upc       utgt      utk
        vecs[0]  = mk(I,  O, O, Z,        Z,        O, O, O, O,   O, O, O, Z,        O, Z,        Z,        O);
        vecs[1]  = mk(O,  I, I, 32'h100,  32'h104,  O, O, O, I,   O, O, O, Z,        I, 32'h100,  32'h104,  O);
        vecs[2]  = mk(O,  O, O, Z,        Z,        O, O, O, I,   O, O, O, Z,        O, Z,        Z,        O);
        vecs[3]  = mk(O,  I, I, 32'h200,  32'h380,  I, I, O, I,   I, I, O, 32'h380,  I, 32'h200,  32'h380,  I);
        vecs[4]  = mk(O,  I, I, 32'h300,  32'h304,  O, I, O, I,   O, I, I, 32'h380,  O, Z,        Z,        O);
        vecs[5]  = mk(O,  I, I, 32'h310,  32'h314,  I, O, I, I,   O, I, I, 32'h380,  O, Z,        Z,        O);
        vecs[6]  = mk(O,  I, I, 32'h320,  32'h324,  O, I, O, I,   O, O, O, 32'h380,  O, Z,        Z,        O);
        vecs[7]  = mk(O,  O, O, Z,        Z,        O, O, O, I,   O, O, O, 32'h380,  O, Z,        Z,        O);
        vecs[8]  = mk(O,  I, I, 32'h400,  32'h500,  I, O, I, O,   I, I, O, 32'h500,  I, 32'h400,  32'h500,  I);
        vecs[9]  = mk(O,  O, O, Z,        Z,        O, O, O, O,   O, I, I, 32'h500,  I, 32'h400,  32'h500,  I);
        vecs[10] = mk(O,  O, O, Z,        Z,        O, O, O, I,   O, I, I, 32'h500,  O, Z,        Z,        O);
        vecs[11] = mk(O,  O, O, Z,        Z,        O, O, O, O,   O, O, O, 32'h500,  O, Z,        Z,        O);

        rst = 1'b1;
        drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        m_left = 0; m_rpc = 0; m_branch = 0; m_mis = 0; m_drop = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            drive(vecs[i].v, vecs[i].br, vecs[i].pc, vecs[i].nx, vecs[i].nj,
                  vecs[i].bf, vecs[i].af, vecs[i].rdy);
            rst = vecs[i].rst;
            cycle();
            chk({tg, ".redirect"}, 32'(redirect_o), 32'(vecs[i].e_redir));
            chk({tg, ".flush"},    32'(flush_o),    32'(vecs[i].e_flush));
            chk({tg, ".stall"},    32'(stall_o),    32'(vecs[i].e_stall));
            chk({tg, ".rpc"},      redirect_pc_o,   vecs[i].e_rpc);
            chk({tg, ".uvalid"},   32'(upd_valid_o), 32'(vecs[i].e_uv));
            if (vecs[i].e_uv) begin
                chk({tg, ".upc"},  upd_pc_o,         vecs[i].e_upc);
                chk({tg, ".utgt"}, upd_target_o,     vecs[i].e_utgt);
                chk({tg, ".utkn"}, 32'(upd_taken_o), 32'(vecs[i].e_utk));
            end
            check_model(tg);
            $display("%s: rst=%b pc=%h redir=%b flush=%b stall=%b rpc=%h uvalid=%b",
                     tg, vecs[i].rst, vecs[i].pc, redirect_o, flush_o, stall_o,
                     redirect_pc_o, upd_valid_o);
        end

        // ---- overflow: three resolves with the consumer stalled ----
        do_reset();
        step("ovf.push0", I, I, 32'hA0, 32'hA4, O, O, O, O);
        step("ovf.push1", I, I, 32'hB0, 32'hB4, I, O, O, O);
        step("ovf.push2", I, I, 32'hC0, 32'hC4, O, O, O, O);
        chk("ovf.head_pc", upd_pc_o, 32'hA0);
        chk("ovf.head_valid", 32'(upd_valid_o), 32'd1);
`ifdef BRANCH_STATS_EN
        chk("ovf.stat_drop", stat_drop_o, 32'd1);
`endif
        step("ovf.hold", O, O, Z, Z, O, O, O, O);
        chk("ovf.head_stable", upd_pc_o, 32'hA0);
        step("ovf.pop0", O, O, Z, Z, O, O, O, I);
        chk("ovf.second_pc", upd_pc_o, 32'hB0);
        chk("ovf.second_tkn", 32'(upd_taken_o), 32'd1);
        step("ovf.pop1", O, O, Z, Z, O, O, O, I);
        chk("ovf.empty", 32'(upd_valid_o), 32'd0);

        // ---- full queue with push and pop in the same cycle ----
        do_reset();
        step("pp.push0", I, I, 32'h10, 32'h14, O, O, O, O);
        step("pp.push1", I, I, 32'h20, 32'h24, O, O, O, O);
        step("pp.both",  I, I, 32'h30, 32'h34, I, O, O, I);
        chk("pp.head_after_both", upd_pc_o, 32'h20);
        step("pp.pop0", O, O, Z, Z, O, O, O, I);
        chk("pp.tail_entry_pc", upd_pc_o, 32'h30);
        chk("pp.tail_entry_tgt", upd_target_o, 32'h34);
        step("pp.pop1", O, O, Z, Z, O, O, O, I);
        chk("pp.empty", 32'(upd_valid_o), 32'd0);

        // ---- reset in RECOVER with two queued ----
        do_reset();
        step("rr.push0", I, I, 32'h10, 32'h14, O, O, O, O);
        step("rr.push1", I, I, 32'h20, 32'h24, O, O, O, O);
        step("rr.mis",   I, I, 32'h40, 32'h80, I, I, O, O);
        chk("rr.redirect", 32'(redirect_o), 32'd1);
        step("rr.recover", O, O, Z, Z, O, O, O, O);
        chk("rr.in_recover", 32'(stall_o), 32'd1);
        drive(O, O, Z, Z, O, O, O, I);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_model("rr.rst");
        chk("rr.stall0", 32'(stall_o), 32'd0);
        chk("rr.flush0", 32'(flush_o), 32'd0);
        chk("rr.uvalid0", 32'(upd_valid_o), 32'd0);
        chk("rr.rpc0", redirect_pc_o, 32'd0);
        step("rr.idle", O, O, Z, Z, O, O, O, O);
        chk("rr.still_idle", 32'(stall_o | redirect_o), 32'd0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 63) == 0);
            cycle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
